proc_seq: RTL

Parametrised stage sequencer and shared-memory arbiter for the packet-processing pipeline. Drives NUM_STAGES processing stages (parser, matcher, executor, …) in strict order with a level start/ready handshake, routes the single data-memory port to the active stage, skips stages masked off per packet, and aborts any stage that exceeds a cycle budget. Sits between the packet loader and the stage modules. Also reports per-packet status and running completion/error counts.

---
 rtl/proc_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/proc_seq.sv
// proc_seq: strict-order stage sequencer with per-stage watchdog
// and data-memory port routing to the active stage.
module proc_seq #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [NUM_STAGES-1:0]            stage_en_i,
  output logic                             ready_o,
  output logic                             error_o,
  output logic [2:0]                       err_stage_o,
  output logic [NUM_STAGES-1:0]            stg_start_o,
  input  logic [NUM_STAGES-1:0]            stg_ready_i,
  input  logic [NUM_STAGES-1:0]            stg_mem_ce_i,
  input  logic [NUM_STAGES-1:0]            stg_mem_we_i,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] stg_mem_addr_i,
  input  logic [NUM_STAGES*4-1:0]          stg_mem_width_i,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] stg_mem_data_i,
  output logic                             mem_ce_o,
  output logic                             mem_we_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [3:0]                       mem_width_o,
  output logic [DATA_WIDTH-1:0]            mem_data_o,
  output logic [CNT_WIDTH-1:0]             pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]             err_cnt_o
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_d;
  logic [2:0]            cur, cur_d;
  logic [NUM_STAGES-1:0] en_q, en_d;
  logic [WD_W-1:0]       wd_cnt, wd_d;
  logic [2:0]            mux_sel, sel_d;
  logic [NUM_STAGES-1:0] start_d;
  logic                  rdy_d, err_d;
  logic [2:0]            estg_d;
  logic [CNT_WIDTH-1:0]  pkt_d, ecnt_d;

  logic [2:0]            first, nxt;
  logic                  first_ok, nxt_ok;
  logic [NUM_STAGES-1:0] cur_oh;
  logic                  rdy_cur;

  assign cur_oh  = NUM_STAGES'(1) << cur;
  assign rdy_cur = |(stg_ready_i & cur_oh);

  // lowest requested stage, and lowest enabled stage above cur
  always_comb begin
    first    = '0;
    first_ok = 1'b0;
    nxt      = '0;
    nxt_ok   = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_en_i[i]) begin
        first    = 3'(i);
        first_ok = 1'b1;
      end
      if (en_q[i] && (3'(i) > cur)) begin
        nxt    = 3'(i);
        nxt_ok = 1'b1;
      end
    end
  end

  // next-state and next-output logic of the sequencer
  always_comb begin
    state_d = state;
    cur_d   = cur;
    en_d    = en_q;
    wd_d    = wd_cnt;
    sel_d   = mux_sel;
    start_d = stg_start_o;
    rdy_d   = ready_o;
    err_d   = error_o;
    estg_d  = err_stage_o;
    pkt_d   = pkt_cnt_o;
    ecnt_d  = err_cnt_o;
    case (state)
      FREE: begin
        if (start_i) begin
          rdy_d = 1'b0;
          err_d = 1'b0;
          en_d  = stage_en_i;
          if (!first_ok) begin
            rdy_d   = 1'b1;
            pkt_d   = pkt_cnt_o + CNT_WIDTH'(1);
            state_d = DONE;
          end else begin
            cur_d   = first;
            start_d = NUM_STAGES'(1) << first;
            sel_d   = first;
            wd_d    = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (rdy_cur) begin
          if (nxt_ok) begin
            cur_d   = nxt;
            start_d = NUM_STAGES'(1) << nxt;
            sel_d   = nxt;
            wd_d    = '0;
          end else begin
            start_d = '0;
            rdy_d   = 1'b1;
            sel_d   = '0;
            pkt_d   = pkt_cnt_o + CNT_WIDTH'(1);
            state_d = DONE;
          end
        end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
          start_d = '0;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
          estg_d  = cur;
          sel_d   = '0;
          ecnt_d  = err_cnt_o + CNT_WIDTH'(1);
          state_d = DONE;
        end else begin
          wd_d = wd_cnt + WD_W'(1);
        end
      end
      DONE: begin
        if (!start_i) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FREE;
      cur         <= '0;
      en_q        <= '0;
      wd_cnt      <= '0;
      mux_sel     <= '0;
      stg_start_o <= '0;
      ready_o     <= 1'b0;
      error_o     <= 1'b0;
      err_stage_o <= '0;
      pkt_cnt_o   <= '0;
      err_cnt_o   <= '0;
    end else begin
      state       <= state_d;
      cur         <= cur_d;
      en_q        <= en_d;
      wd_cnt      <= wd_d;
      mux_sel     <= sel_d;
      stg_start_o <= start_d;
      ready_o     <= rdy_d;
      error_o     <= err_d;
      err_stage_o <= estg_d;
      pkt_cnt_o   <= pkt_d;
      err_cnt_o   <= ecnt_d;
    end
  end

  // memory port follows mux_sel; out-of-range falls back to stage 0
  always_comb begin
    mem_ce_o    = stg_mem_ce_i[0];
    mem_we_o    = stg_mem_we_i[0];
    mem_addr_o  = stg_mem_addr_i[0 +: ADDR_WIDTH];
    mem_width_o = stg_mem_width_i[0 +: 4];
    mem_data_o  = stg_mem_data_i[0 +: DATA_WIDTH];
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (int'(mux_sel) == i) begin
        mem_ce_o    = stg_mem_ce_i[i];
        mem_we_o    = stg_mem_we_i[i];
        mem_addr_o  = stg_mem_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_width_o = stg_mem_width_i[i*4 +: 4];
        mem_data_o  = stg_mem_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
